// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The control bundle packs every pipeline-register enable and bubble strobe into one value.
package pipe_ctrl_pkg;

  typedef enum logic {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } state_e;

  // Register $zero never carries a real dependency.
  localparam int unsigned REG_ZERO = 0;

  // Field order: enables PC..MEM/WB, then the three flush strobes.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } ctrl_t;

  localparam ctrl_t CtrlRun      = 8'b11111_000;
  localparam ctrl_t CtrlReset    = 8'b11111_111;
  localparam ctrl_t CtrlMemStall = 8'b00001_001;
  localparam ctrl_t CtrlBranch   = 8'b11111_110;
  localparam ctrl_t CtrlLoadUse  = 8'b00111_010;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in ID/EX whose destination is read by the
// instruction in IF/ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  output logic             hit
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (idex_rt == ifid_rs);
  assign rt_match = ifid_uses_rt && (idex_rt == ifid_rt);
  assign hit      = idex_memread && (idex_rt != REG_W'(REG_ZERO)) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, data-memory waits and
// taken-branch squashes. Outputs are Mealy and act on the same clock edge.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             lu_hit;
  logic             mem_stall;
  ctrl_t            ctrl;

  load_use_detect #(
    .REG_W(REG_W)
  ) u_load_use_detect (
    .idex_memread(idex_memread),
    .idex_rt     (idex_rt),
    .ifid_rs     (ifid_rs),
    .ifid_rt     (ifid_rt),
    .ifid_uses_rt(ifid_uses_rt),
    .hit         (lu_hit)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    ctrl       = CtrlRun;

    // Once waiting, only dmem_ready matters: the request is frozen in EX/MEM.
    if (state_q == StRun) begin
      mem_stall = dmem_req && !dmem_ready;
    end else begin
      mem_stall = !dmem_ready;
    end

    if (mem_stall) begin
      ctrl    = CtrlMemStall;
      state_d = StMemWait;
      if (state_q == StRun) begin
        wait_cnt_d = WaitW'(1);
      end else if (wait_cnt_q != WaitMax) begin
        wait_cnt_d = wait_cnt_q + WaitW'(1);
      end
      // Flag on the edge that completes the MEM_TIMEOUT-th consecutive wait cycle.
      if (wait_cnt_d == WaitMax) begin
        timeout_d = 1'b1;
      end
    end else begin
      state_d    = StRun;
      wait_cnt_d = '0;
      if (branch_taken) begin
        ctrl = CtrlBranch;
      end else if (lu_hit) begin
        ctrl = CtrlLoadUse;
      end
    end

    if (reset) begin
      ctrl = CtrlReset;
    end

    stall_d = stall_q;
    if (!ctrl.pc_en && !reset && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_en      = ctrl.ifid_en;
  assign idex_en      = ctrl.idex_en;
  assign exmem_en     = ctrl.exmem_en;
  assign memwb_en     = ctrl.memwb_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_flush   = ctrl.idex_flush;
  assign memwb_flush  = ctrl.memwb_flush;
  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;

endmodule
